// File: rtl/nibble_frame_pkg.sv
// Shared definitions for the nibble frame link (transmitter and receiver).
// Optional checksum nibble is enabled by defining NIBBLE_FRAME_CHK_EN.
package nibble_frame_pkg;

  localparam logic [3:0] SYNC_NIB_DEFAULT = 4'hB;
  localparam logic [3:0] IDLE_NIB_DEFAULT = 4'h0;

  localparam int unsigned FRAME_LEN_BASE = 4;
  localparam int unsigned CHK_LEN        = 1;

`ifdef NIBBLE_FRAME_CHK_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE + CHK_LEN;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSync = 3'd1,
    StD2   = 3'd2,
    StD1   = 3'd3,
    StD0   = 3'd4,
    StGap  = 3'd5,
    StChk  = 3'd6
  } state_t;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StSync = 3'd1,
    StD2   = 3'd2,
    StD1   = 3'd3,
    StD0   = 3'd4,
    StGap  = 3'd5
  } state_t;
`endif

  // XOR of the sync nibble and all three data nibbles.
  function automatic logic [3:0] frame_chk(logic [3:0] sync_nib, logic [11:0] word);
    return sync_nib ^ word[11:8] ^ word[7:4] ^ word[3:0];
  endfunction

endpackage

// File: rtl/nibble_frame_tx_if.sv
// Word handshake plus nibble link signals of the nibble frame transmitter.
// The master side is the word producer / link observer, the slave side is the transmitter.
interface nibble_frame_tx_if;

  logic [11:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [3:0]  tx_nib;
  logic        tx_valid;
  logic        tx_sof;
  logic        busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  tx_nib,
    input  tx_valid,
    input  tx_sof,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output tx_nib,
    output tx_valid,
    output tx_sof,
    output busy
  );

endinterface

// File: rtl/nibble_frame_tx.sv
// Nibble frame transmitter: SYNC, three data nibbles MSB first, optional checksum, then a gap.
// Define NIBBLE_FRAME_CHK_EN to append the checksum nibble.
module nibble_frame_tx
  import nibble_frame_pkg::*;
#(
  parameter logic [3:0]  SYNC_NIB   = SYNC_NIB_DEFAULT,
  parameter logic [3:0]  IDLE_NIB   = IDLE_NIB_DEFAULT,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             rst_,
  nibble_frame_tx_if.slave bus
);

  localparam logic [3:0] GapLoad = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [11:0] word_q, word_d;
  logic [3:0]  gap_q, gap_d;
  logic [3:0]  nib_q, nib_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        busy_q, busy_d;

  assign bus.data_ready = (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        if (bus.data_valid) begin
          word_d  = bus.data_in;
          state_d = StSync;
        end
      end
      StSync: state_d = StD2;
      StD2:   state_d = StD1;
      StD1:   state_d = StD0;
`ifdef NIBBLE_FRAME_CHK_EN
      StD0:   state_d = StChk;
      StChk: begin
        gap_d = GapLoad;
        if (GAP_CYCLES == 0) state_d = StIdle;
        else                 state_d = StGap;
      end
`else
      StD0: begin
        gap_d = GapLoad;
        if (GAP_CYCLES == 0) state_d = StIdle;
        else                 state_d = StGap;
      end
`endif
      StGap: begin
        if (gap_q == 4'd0) state_d = StIdle;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with the state.
  always_comb begin
    nib_d   = IDLE_NIB;
    valid_d = 1'b1;
    sof_d   = 1'b0;
    busy_d  = 1'b1;
    case (state_d)
      StSync: begin
        nib_d = SYNC_NIB;
        sof_d = 1'b1;
      end
      StD2: nib_d = word_d[11:8];
      StD1: nib_d = word_d[7:4];
      StD0: nib_d = word_d[3:0];
`ifdef NIBBLE_FRAME_CHK_EN
      StChk: nib_d = frame_chk(SYNC_NIB, word_d);
`endif
      StGap: valid_d = 1'b0;
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      word_q  <= '0;
      gap_q   <= '0;
      nib_q   <= IDLE_NIB;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
      nib_q   <= nib_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.tx_nib   = nib_q;
  assign bus.tx_valid = valid_q;
  assign bus.tx_sof   = sof_q;
  assign bus.busy     = busy_q;

  // An idle link must never look like the start of a frame.
  sync_idle_distinct: assert property (@(posedge CLK) IDLE_NIB != SYNC_NIB);
  gap_in_range: assert property (@(posedge CLK) GAP_CYCLES <= 15);

endmodule

// File: tb/tb_nibble_frame_tx.sv
// Bench for nibble_frame_tx: three instances (gap 1, 0, 3) against a queue-based frame model.
module tb_nibble_frame_tx;
  import nibble_frame_pkg::*;

  localparam int NDUT = 3;
`ifdef NIBBLE_FRAME_CHK_EN
  localparam int L = 5;
  localparam bit CHK = 1'b1;
`else
  localparam int L = 4;
  localparam bit CHK = 1'b0;
`endif

  function automatic int gap_of(int g);
    case (g)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [11:0] data_in = '0;
  logic        data_valid = 1'b0;

  logic [3:0] nib [NDUT];
  logic       vld [NDUT];
  logic       sof [NDUT];
  logic       bsy [NDUT];
  logic       rdy [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    nibble_frame_tx_if bus ();
    assign bus.data_in    = data_in;
    assign bus.data_valid = data_valid;
    assign nib[g] = bus.tx_nib;
    assign vld[g] = bus.tx_valid;
    assign sof[g] = bus.tx_sof;
    assign bsy[g] = bus.busy;
    assign rdy[g] = bus.data_ready;
    nibble_frame_tx #(
      .SYNC_NIB   (4'hB),
      .IDLE_NIB   (4'h0),
      .GAP_CYCLES (gap_of(g))
    ) u_dut (
      .CLK  (clk),
      .rst_ (rst_),
      .bus  (bus.slave)
    );
  end

  int total = 0;
  int bad = 0;

  task automatic check(string name, int g, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  // Model: each cycle's expected outputs as a queue of beats per instance.
  typedef struct packed {
    logic [3:0] nib;
    logic       vld;
    logic       sof;
    logic       bsy;
  } beat_t;

  function automatic beat_t mk(logic [3:0] n, logic v, logic s, logic b);
    beat_t r;
    r.nib = n; r.vld = v; r.sof = s; r.bsy = b;
    return r;
  endfunction

  beat_t q [NDUT][$];
  beat_t cur [NDUT];

  initial begin
    for (int g = 0; g < NDUT; g++) cur[g] = mk(4'h0, 1'b0, 1'b0, 1'b0);
    forever begin
      @(posedge clk or negedge rst_);
      for (int g = 0; g < NDUT; g++) begin
        if (!rst_) begin
          q[g].delete();
          cur[g] = mk(4'h0, 1'b0, 1'b0, 1'b0);
        end else begin
          if (!cur[g].bsy && data_valid) begin
            q[g].push_back(mk(4'hB, 1'b1, 1'b1, 1'b1));
            q[g].push_back(mk(data_in[11:8], 1'b1, 1'b0, 1'b1));
            q[g].push_back(mk(data_in[7:4], 1'b1, 1'b0, 1'b1));
            q[g].push_back(mk(data_in[3:0], 1'b1, 1'b0, 1'b1));
            if (CHK)
              q[g].push_back(mk(4'hB ^ data_in[11:8] ^ data_in[7:4] ^ data_in[3:0],
                                1'b1, 1'b0, 1'b1));
            for (int i = 0; i < gap_of(g); i++) q[g].push_back(mk(4'h0, 1'b0, 1'b0, 1'b1));
          end
          cur[g] = (q[g].size() > 0) ? q[g].pop_front() : mk(4'h0, 1'b0, 1'b0, 1'b0);
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        check("nib", g, nib[g], cur[g].nib);
        check("tx_valid", g, vld[g], cur[g].vld);
        check("tx_sof", g, sof[g], cur[g].sof);
        check("busy", g, bsy[g], cur[g].bsy);
        if (rst_) check("data_ready", g, rdy[g], !cur[g].bsy);
      end
    end
  end

  logic [3:0] rn [NDUT][16];
  logic       rv [NDUT][16];
  logic       rs [NDUT][16];
  logic       rb [NDUT][16];
  logic       rr [NDUT][16];

  task automatic record(int c);
    for (int g = 0; g < NDUT; g++) begin
      rn[g][c] = nib[g]; rv[g][c] = vld[g]; rs[g][c] = sof[g];
      rb[g][c] = bsy[g]; rr[g][c] = rdy[g];
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 0, n < 50, 1);
  endtask

  // Sends one word from idle and captures cycles 1..L+4 after the accept edge.
  task automatic run_word(logic [11:0] w);
    data_in = w;
    data_valid = 1'b1;
    @(posedge clk);
    #2;
    data_valid = 1'b0;
    data_in = 12'hFFF;
    for (int c = 1; c <= L + 4; c++) begin
      @(negedge clk);
      record(c);
    end
  endtask

  task automatic check_frame(string name, logic [19:0] e, int base);
    logic [3:0] en;
    for (int c = 1; c <= L; c++) begin
      en = e[19 - 4 * (c - 1) -: 4];
      check({name, "_nib"}, 0, rn[0][base + c], en);
      check({name, "_vld"}, 0, rv[0][base + c], 1);
      check({name, "_sof"}, 0, rs[0][base + c], (c == 1));
    end
  endtask

  task automatic check_gaps(string name);
    check({name, "_gap_vld"}, 0, rv[0][L + 1], 0);
    check({name, "_gap_busy"}, 0, rb[0][L + 1], 1);
    check({name, "_gap_rdy"}, 0, rr[0][L + 1], 0);
    check({name, "_rdy_after"}, 0, rr[0][L + 2], 1);
    check({name, "_busy_after"}, 0, rb[0][L + 2], 0);
    check({name, "_nogap_rdy"}, 1, rr[1][L + 1], 1);
    check({name, "_nogap_busy"}, 1, rb[1][L + 1], 0);
    for (int c = L + 1; c <= L + 3; c++) begin
      check({name, "_gap3_busy"}, 2, rb[2][c], 1);
      check({name, "_gap3_rdy"}, 2, rr[2][c], 0);
      check({name, "_gap3_nib"}, 2, rn[2][c], 4'h0);
    end
    check({name, "_gap3_rdy_after"}, 2, rr[2][L + 4], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check("reset_nib", g, nib[g], 4'h0);
      check("reset_vld", g, vld[g], 0);
      check("reset_sof", g, sof[g], 0);
      check("reset_busy", g, bsy[g], 0);
    end
    #1 rst_ = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) check("ready_after_reset", g, rdy[g], 1);

    // Single words, including all-zero and sync-valued data.
    wait_idle();
    run_word(12'hA5C);
    check_frame("a5c", CHK ? 20'hBA5C8 : 20'hBA5C0, 0);
    check_gaps("a5c");
    wait_idle();
    run_word(12'h000);
    check_frame("w000", 20'hB000B, 0);
    check_gaps("w000");
    wait_idle();
    run_word(12'hBBB);
    check_frame("wbbb", 20'hBBBB0, 0);

    // Back-to-back with data_valid held; data_in scribbled while busy.
    wait_idle();
    data_in = 12'h123;
    data_valid = 1'b1;
    @(posedge clk);
    #2 data_in = 12'hFFF;
    for (int c = 1; c <= 2 * L + 3; c++) begin
      @(negedge clk);
      record(c);
      if (c == L + 1) data_in = 12'h456;
    end
    data_valid = 1'b0;
    check_frame("b2b_first", 20'hB123B, 0);
    check("b2b_gap_vld", 0, rv[0][L + 1], 0);
    check("b2b_rdy", 0, rr[0][L + 2], 1);
    check_frame("b2b_second", 20'hB456C, L + 2);

    // Reset in the middle of a frame (D1).
    wait_idle();
    data_in = 12'h7E1;
    data_valid = 1'b1;
    @(posedge clk);
    #2 data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_nib", 0, nib[0], 4'hE);
    #1 rst_ = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check("abort_nib", g, nib[g], 4'h0);
      check("abort_vld", g, vld[g], 0);
      check("abort_sof", g, sof[g], 0);
      check("abort_busy", g, bsy[g], 0);
    end
    repeat (3) @(posedge clk);
    #2 rst_ = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort_no_resend", 0, vld[0], 0);
      check("abort_ready", 0, rdy[0], 1);
    end

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      data_valid = ($urandom_range(0, 2) != 0);
      data_in = ($urandom_range(0, 3) == 0) ? 12'hBBB : 12'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_ = 1'b0;
        #2 rst_ = 1'b1;
      end
    end
    data_valid = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_frame_tx.md
Name: nibble_frame_tx

Overview:
- Transmit side of the 4-bit nibble link whose receiver detects sync nibble 0xB on a 4-bit bus and then checks a 12-bit word.
- Accepts one 12-bit word per valid/ready handshake.
- Emits each word as a framed nibble stream: SYNC, then data MSB-first, with an optional checksum nibble.
- Sits between the word producer and the 4-bit link driver; all outputs are registered.

Parameters:
- SYNC_NIB, 4'hB, sync nibble that opens every frame.
- IDLE_NIB, 4'h0, value driven on tx_nib when no frame is active. Must differ from SYNC_NIB; a simulation assertion flags equality.
- GAP_CYCLES, 1, idle cycles forced after each frame (0..15). 0 means no gap.

Ports:
- CLK  in  1  clock, rising edge.
- rst_  in  1  asynchronous, active-low reset.
- data_in  in  12  word to send. Sampled only on the accept cycle.
- data_valid  in  1  producer has a word.
- data_ready  out  1  block can accept a word this cycle.
- tx_nib  out  4  nibble on the link.
- tx_valid  out  1  tx_nib carries frame content (SYNC, data or checksum).
- tx_sof  out  1  high only on the SYNC nibble cycle.
- busy  out  1  high from the first cycle after accept until the end of the gap.

Behaviour:
- Reset values (asynchronous, while rst_=0):
  - State = IDLE, gap counter = 0, word register = 0.
  - tx_nib = IDLE_NIB, tx_valid = 0, tx_sof = 0, busy = 0.
  - data_ready = 1 once reset releases.
- States: IDLE, SYNC, D2, D1, D0, CHK (macro only), GAP.
- data_ready = (state==IDLE). It is combinational from state only; no dependence on data_valid.
- Accept happens when data_valid & data_ready at a rising edge. On accept, data_in is latched and the next state is SYNC.
- If data_valid=0 in IDLE, the block stays in IDLE.
- Output values per state (registered, i.e. valid in the cycle the state is current):
  - SYNC: tx_nib = SYNC_NIB.
  - D2: tx_nib = word[11:8].
  - D1: tx_nib = word[7:4].
  - D0: tx_nib = word[3:0].
  - CHK: tx_nib = checksum.
  - tx_valid = 1 in SYNC/D2/D1/D0/CHK; tx_sof = 1 only in SYNC.
  - IDLE and GAP: tx_nib = IDLE_NIB, tx_valid = 0.
- Latency: accept at cycle N gives SYNC at cycle N+1 and the last data nibble at N+4 (N+5 with CHK).
- Transitions:
  - SYNC->D2->D1->D0.
  - D0 -> CHK if enabled, otherwise D0 -> GAP (or IDLE when GAP_CYCLES=0).
  - CHK -> GAP, or IDLE when GAP_CYCLES=0.
- GAP: a 4-bit counter loads GAP_CYCLES-1 on entry and decrements; the block leaves to IDLE when the counter reaches 0.
- Minimum frame period = 1 + 4 (+1 CHK) + GAP_CYCLES cycles.
- Ignored inputs:
  - data_in changes after accept are ignored.
  - data_valid is ignored outside IDLE; no queuing, the producer holds.
- busy = 1 in SYNC..GAP, 0 in IDLE.
- A word whose nibble equals SYNC_NIB is sent unmodified; no escaping. The receiver resolves this by position.
- Reset mid-frame aborts immediately: the partial frame is dropped, tx_valid drops asynchronously, and nothing is resent.

Optional Feature:
- Macro: NIBBLE_FRAME_CHK_EN.
- Defined:
  - The CHK state is present.
  - Checksum = SYNC_NIB ^ word[11:8] ^ word[7:4] ^ word[3:0], sent after D0 with tx_valid=1.
  - Frame = 5 nibbles.
- Undefined:
  - No CHK state or logic.
  - Frame = 4 nibbles, and D0 goes directly to GAP/IDLE.

Decomposition:
- Shared package nibble_frame_pkg holds:
  - State encoding constants (IDLE..GAP).
  - Default SYNC_NIB 4'hB and IDLE_NIB 4'h0.
  - FRAME_LEN_BASE=4 and CHK_LEN=1.
  - The receiver reuses the same package.
- No sub-module. The FSM, word register, gap counter and output register sit in one module (~150-200 lines).

Test Plan:
- Reset: hold rst_=0 for 3 cycles, assert it mid-frame in D1 -> outputs immediately IDLE_NIB/0/0/0; data_ready=1 after release; no further nibbles from the aborted word.
- Single word 0xA5C, macro off, GAP=1: accept at cycle 0 -> tx_nib B,A,5,C at cycles 1-4 with tx_valid=1; tx_sof=1 only at cycle 1; gap at cycle 5; data_ready=1 at cycle 6.
- Same word 0xA5C, macro on -> nibbles B,A,5,C,8 (checksum 0x8) at cycles 1-5.
- Word 0x000 with macro on: nibbles B,0,0,0,B.
- Back-to-back 0x123 then 0x456, data_valid held high, GAP=1 -> 0x456 accepted at cycle 6 and SYNC at cycle 7. data_in changed to 0xFFF during cycles 1-4 has no effect.
- GAP_CYCLES=0 -> D0 at cycle 4, IDLE at cycle 5, next SYNC at cycle 6. GAP_CYCLES=3 -> three IDLE_NIB cycles with busy=1 before data_ready rises.
- Word 0xBBB: nibbles B,B,B,B, with tx_sof=1 only on the first.
